// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter with a valid/ready load interface. A load of period P
//   counts P en-ticks to zero. Expiry produces a one-cycle done pulse. In
//   auto-reload mode the period restarts immediately, with no gap cycle. In
//   one-shot mode the timer parks in DONE with cnt=0 until it is loaded again.
//   A zero-length load goes straight to DONE and pulses done.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   load_valid  load request, qualified by load_ready
//   load_ready  high in IDLE or DONE (a load is accepted this cycle)
//   load_val    period to count down from
//   reload      sampled with the load: 1=auto-reload, 0=one-shot
//   en          count tick
//   abort       cancel a running count (ignored when not running)
//   cnt         remaining count (registered)
//   busy        state is RUN
//   done        one-cycle pulse after expiry or a zero-length load
//   expired     state is DONE
//   periods     completed periods since the last load (wraps)
module countdown_timer #(
  parameter int width      = 8,
  parameter int pcnt_width = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [width-1:0]      load_val,
  input  logic                  reload,
  input  logic                  en,
  input  logic                  abort,
  output logic [width-1:0]      cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  expired,
  output logic [pcnt_width-1:0] periods
);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_run  = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  logic [1:0]            state_reg,   state_next;
  logic [width-1:0]      cnt_reg,     cnt_next;
  logic [width-1:0]      period_reg,  period_next;
  logic                  mode_reg,    mode_next;
  logic                  done_reg,    done_next;
  logic [pcnt_width-1:0] periods_reg, periods_next;

  assign busy       = (state_reg == st_run);
  assign expired    = (state_reg == st_done);
  assign load_ready = (state_reg == st_idle) || (state_reg == st_done);
  assign cnt        = cnt_reg;
  assign done       = done_reg;
  assign periods    = periods_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    period_next  = period_reg;
    mode_next    = mode_reg;
    done_next    = 1'b0;
    periods_next = periods_reg;

    case (state_reg)
      st_idle, st_done: begin
        if (load_valid) begin
          cnt_next     = load_val;
          period_next  = load_val;
          mode_next    = reload;
          periods_next = '0;
          if (load_val == '0) begin
            state_next = st_done;
            done_next  = 1'b1;
          end else begin
            state_next = st_run;
          end
        end
      end
      st_run: begin
        // abort takes priority over an expiry in the same cycle
        if (abort) begin
          state_next = st_idle;
          cnt_next   = '0;
        end else if (en) begin
          // RUN is only ever entered with a non-zero count, so anything that
          // is not above 1 is the expiry tick; 0 is never decremented.
          if (cnt_reg > width'(1)) begin
            cnt_next = cnt_reg - width'(1);
          end else begin
            done_next    = 1'b1;
            periods_next = periods_reg + pcnt_width'(1);
            if (mode_reg) begin
              cnt_next = period_reg;
            end else begin
              cnt_next   = '0;
              state_next = st_done;
            end
          end
        end
      end
      default: begin
        state_next = st_idle;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= st_idle;
      cnt_reg     <= '0;
      period_reg  <= '0;
      mode_reg    <= 1'b0;
      done_reg    <= 1'b0;
      periods_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      period_reg  <= period_next;
      mode_reg    <= mode_next;
      done_reg    <= done_next;
      periods_reg <= periods_next;
    end
  end

endmodule
